// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts one ALU command at a time, fetches operands from a small register file,
// drives the combinational ALU, writes back and returns the result. Optional macro: ALU_SEQ_CARRY_CHAIN_EN.
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [3:0]       cmd_select,
  input  logic [IDX_W-1:0] cmd_src_a,
  input  logic [IDX_W-1:0] cmd_src_b,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic             cmd_use_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_compare,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_compare,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] rf [NREGS];
  logic             carry_flag;
  logic [IDX_W-1:0] dst_p0;
  logic             cin_next;
  logic             accept;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == S_RESP);
  assign dbg_data  = rf[dbg_idx];
  // The carry flag and the reported carry are captured together, so one register serves both.
  assign rsp_carry = carry_flag;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign cin_next = cmd_use_carry ? carry_flag : 1'b0;
`else
  logic unused_use_carry;
  assign unused_use_carry = cmd_use_carry;
  assign cin_next         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      carry_flag   <= 1'b0;
      dst_p0       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
      rsp_data     <= '0;
      rsp_compare  <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        // accept stage: operands are latched here, ahead of any write-back to the same register
        S_IDLE: begin
          if (accept) begin
            alu_a        <= rf[cmd_src_a];
            alu_b        <= cmd_imm_en ? cmd_imm : rf[cmd_src_b];
            alu_select   <= cmd_select;
            alu_mode     <= cmd_mode;
            alu_carry_in <= cin_next;
            dst_p0       <= cmd_dst;
            state        <= S_EXEC;
          end
        end
        // execute stage: ALU settles for one cycle, result captured at the closing edge
        S_EXEC: begin
          rf[dst_p0]  <= alu_result;
          carry_flag  <= alu_carry;
          rsp_data    <= alu_result;
          rsp_compare <= alu_compare;
          state       <= S_RESP;
        end
        // response stage: outputs held until consumed
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
